// File: rtl/axi_pkg.sv
// axi_pkg: AXI encodings, response codes, FSM state constants and request-legality helper
package axi_pkg;
  typedef logic [1:0] burst_t;
  typedef logic [2:0] size_t;
  typedef logic [1:0] resp_t;
  typedef logic [1:0] state_t;
  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;
  localparam burst_t BURST_RSVD  = 2'b11;
  localparam size_t SIZE_1B = 3'd0;
  localparam size_t SIZE_2B = 3'd1;
  localparam size_t SIZE_4B = 3'd2;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_SEND = 2'd3;
  // A request is flagged for the whole burst when the beat is wider than the
  // 32-bit bus, the burst type is reserved, or a WRAP length is not 2/4/8/16.
  function automatic logic req_illegal(input size_t size, input logic [7:0] len, input burst_t burst);
    return size > SIZE_4B || burst == BURST_RSVD ||
           (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
endpackage

// File: rtl/axi_addr_gen.sv
// axi_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts
//   addr/size/len/burst: current beat address and burst attributes
//   boundary: wrap boundary (only used for WRAP); next_addr: following beat address
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  size_t             size,
  input  logic [7:0]        len,
  input  burst_t            burst,
  input  logic [ADDR_W-1:0] boundary,
  output logic [ADDR_W-1:0] next_addr
);
  logic [ADDR_W:0] bytes, total, inc;
  assign bytes = (ADDR_W+1)'(1) << size;
  assign total = ((ADDR_W+1)'(len) + (ADDR_W+1)'(1)) << size;
  // One extra bit keeps the wrap compare correct when the window ends at 2^ADDR_W.
  assign inc = {1'b0, addr} + bytes;
  assign next_addr = burst == BURST_FIXED ? addr :
                     (burst == BURST_WRAP && inc >= {1'b0, boundary} + total) ? boundary :
                     inc[ADDR_W-1:0];
endmodule

// File: rtl/read_data_slave.sv
// read_data_slave: AXI read-data responder, one memory read per R beat
//   aclk/areset: clock, async active-high reset
//   start + start_*: accepted AR request; busy: burst in progress
//   mem_en/mem_addr -> memory, mem_rdata/mem_err <- memory one cycle later
//   rdata/rresp/rlast/rvalid/rready: R channel
module read_data_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        start_len,
  input  logic [2:0]        start_size,
  input  logic [1:0]        start_burst,
  output logic              busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);
  state_t            state;
  logic [ADDR_W-1:0] cur_addr, boundary, next_addr, wrap_mask;
  logic [7:0]        len_q, beat_cnt;
  size_t             size_q;
  burst_t            burst_q;
  logic              req_err, start_bad;
  assign start_bad = req_illegal(start_size, start_len, start_burst);
  // Only meaningful for legal WRAP requests, whose window is a power of two.
  assign wrap_mask = ((ADDR_W'(start_len) + ADDR_W'(1)) << start_size) - ADDR_W'(1);
  assign busy     = state != ST_IDLE;
  assign mem_en   = state == ST_READ;
  assign mem_addr = cur_addr;
  axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (cur_addr),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .boundary  (boundary),
    .next_addr (next_addr)
  );
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      boundary <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      size_q   <= SIZE_1B;
      burst_q  <= BURST_FIXED;
      req_err  <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      rlast    <= 1'b0;
      rvalid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          // Flagged requests still walk len+1 beats, as INCR of at most 4 bytes.
          cur_addr <= start_addr;
          boundary <= start_addr & ~wrap_mask;
          beat_cnt <= '0;
          len_q    <= start_len;
          size_q   <= start_bad && start_size > SIZE_4B ? SIZE_4B : start_size;
          burst_q  <= start_bad ? BURST_INCR : start_burst;
          req_err  <= start_bad;
          state    <= ST_READ;
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          rdata  <= req_err ? '0 : mem_rdata;
          rresp  <= req_err || mem_err ? RESP_SLVERR : RESP_OKAY;
          rlast  <= beat_cnt == len_q;
          rvalid <= 1'b1;
          state  <= ST_SEND;
        end
        default: if (rready) begin
          rvalid <= 1'b0;
          if (rlast) state <= ST_IDLE;
          else begin
            beat_cnt <= beat_cnt + 8'd1;
            cur_addr <= next_addr;
            state    <= ST_READ;
          end
        end
      endcase
    end
  end
endmodule
